// File: rtl/sipo_y_stream_if.sv
// Stream interface for sipo_y_stream: serial word input side and parallel frame output side.
// The s_in_last / p_out_cnt members exist only when SIPO_FLUSH_EN is defined.
interface sipo_y_stream_if #(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned NUM    = 8
) ();
    logic                    s_in_v;
    logic                    s_in_rdy;
    logic [DATA_W-1:0]       s_in;
    logic                    p_out_v;
    logic                    p_out_rdy;
    logic [NUM*DATA_W-1:0]   p_out;
`ifdef SIPO_FLUSH_EN
    localparam int unsigned CNT_W = $clog2(NUM + 1);
    logic                    s_in_last;
    logic [CNT_W-1:0]        p_out_cnt;

    modport master (
        output s_in_v, s_in, s_in_last, p_out_rdy,
        input  s_in_rdy, p_out_v, p_out, p_out_cnt
    );
    modport slave (
        input  s_in_v, s_in, s_in_last, p_out_rdy,
        output s_in_rdy, p_out_v, p_out, p_out_cnt
    );
`else
    modport master (
        output s_in_v, s_in, p_out_rdy,
        input  s_in_rdy, p_out_v, p_out
    );
    modport slave (
        input  s_in_v, s_in, p_out_rdy,
        output s_in_rdy, p_out_v, p_out
    );
`endif
endinterface

// File: rtl/sipo_y_stream.sv
// sipo_y_stream: gathers NUM serial DATA_W words into one NUM-lane frame, with a one-frame skid.
// Define SIPO_FLUSH_EN to enable early frame close (s_in_last) and the p_out_cnt lane count.
module sipo_y_stream #(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned NUM    = 8,
    parameter int unsigned CNT_W  = $clog2(NUM + 1)
) (
    input  logic            clk,
    input  logic            rst,
    sipo_y_stream_if.slave  bus
);
    localparam int unsigned IDX_W   = $clog2(NUM);
    localparam int unsigned FRAME_W = NUM * DATA_W;

    logic [DATA_W-1:0]  lane_q [NUM];
    logic [DATA_W-1:0]  lane_d [NUM];
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               pend_q, pend_d;
    logic [CNT_W-1:0]   pend_len_q, pend_len_d;
    logic               out_v_q, out_v_d;
    logic [FRAME_W-1:0] out_q, out_d;
`ifdef SIPO_FLUSH_EN
    logic [CNT_W-1:0]   out_cnt_q, out_cnt_d;
`endif

    logic               accept_c;
    logic               close_c;
    logic               done_c;
    logic               free_c;
    logic               hs_c;
    logic [CNT_W-1:0]   len_c;
    logic [FRAME_W-1:0] frame_c;

    assign accept_c = bus.s_in_v & ~pend_q;
    assign free_c   = ~out_v_q | bus.p_out_rdy;
    assign hs_c     = out_v_q & bus.p_out_rdy;
`ifdef SIPO_FLUSH_EN
    assign close_c  = (cnt_q == CNT_W'(NUM - 1)) | bus.s_in_last;
`else
    assign close_c  = (cnt_q == CNT_W'(NUM - 1));
`endif
    assign done_c   = accept_c & close_c;

    // Collect update, frame assembly (lanes at or above the frame length read as zero) and skid control.
    always_comb begin
        lane_d     = lane_q;
        cnt_d      = cnt_q;
        pend_d     = pend_q;
        pend_len_d = pend_len_q;
        out_v_d    = out_v_q;
        out_d      = out_q;
`ifdef SIPO_FLUSH_EN
        out_cnt_d  = out_cnt_q;
`endif
        len_c      = pend_q ? pend_len_q : cnt_q + CNT_W'(1);
        frame_c    = '0;

        if (accept_c) begin
            lane_d[cnt_q[IDX_W-1:0]] = bus.s_in;
            cnt_d = done_c ? '0 : cnt_q + CNT_W'(1);
        end

        for (int unsigned k = 0; k < NUM; k++) begin
            frame_c[k*DATA_W +: DATA_W] = (CNT_W'(k) < len_c) ? lane_d[k] : '0;
        end

        if (done_c && free_c) begin
            out_d   = frame_c;
            out_v_d = 1'b1;
`ifdef SIPO_FLUSH_EN
            out_cnt_d = len_c;
`endif
        end else if (done_c) begin
            pend_d     = 1'b1;
            pend_len_d = len_c;
        end else if (pend_q && hs_c) begin
            out_d   = frame_c;
            out_v_d = 1'b1;
            pend_d  = 1'b0;
`ifdef SIPO_FLUSH_EN
            out_cnt_d = len_c;
`endif
        end else if (hs_c) begin
            out_v_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int unsigned k = 0; k < NUM; k++) begin
                lane_q[k] <= '0;
            end
            cnt_q      <= '0;
            pend_q     <= 1'b0;
            pend_len_q <= '0;
            out_v_q    <= 1'b0;
            out_q      <= '0;
`ifdef SIPO_FLUSH_EN
            out_cnt_q  <= '0;
`endif
        end else begin
            lane_q     <= lane_d;
            cnt_q      <= cnt_d;
            pend_q     <= pend_d;
            pend_len_q <= pend_len_d;
            out_v_q    <= out_v_d;
            out_q      <= out_d;
`ifdef SIPO_FLUSH_EN
            out_cnt_q  <= out_cnt_d;
`endif
        end
    end

    assign bus.s_in_rdy = ~pend_q;
    assign bus.p_out_v  = out_v_q;
    assign bus.p_out    = out_q;
`ifdef SIPO_FLUSH_EN
    assign bus.p_out_cnt = out_cnt_q;
`endif

endmodule

// File: tb/tb_sipo_y_stream.sv
// Scoreboard bench for sipo_y_stream: directed stimulus pushes expected frames, a negedge monitor pops them.
module tb_sipo_y_stream;
    localparam int unsigned DW    = 32;
    localparam int unsigned N     = 8;
    localparam int unsigned CNT_W = $clog2(N + 1);
    localparam int unsigned FW    = N * DW;

    typedef struct packed {
        logic [FW-1:0]    frame;
        logic [CNT_W-1:0] cnt;
    } exp_t;

    logic clk = 1'b0;
    logic rst;
    int   n_vec = 0;
    int   n_err = 0;
    exp_t exp_q[$];

    sipo_y_stream_if #(.DATA_W(DW), .NUM(N)) bus ();

    sipo_y_stream #(.DATA_W(DW), .NUM(N)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #10 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1, "watchdog");
    end

    function automatic logic [FW-1:0] seq(input int unsigned first, input int unsigned n);
        logic [FW-1:0] f = '0;
        for (int unsigned k = 0; k < n; k++) f[k*DW +: DW] = DW'(first + k);
        return f;
    endfunction

    task automatic push(input logic [FW-1:0] f, input int unsigned c);
        exp_t e;
        e.frame = f;
        e.cnt   = CNT_W'(c);
        exp_q.push_back(e);
    endtask

    task automatic chk_b(input string name, input logic act, input logic exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %b expected %b", name, act, exp);
        end
    endtask

    task automatic chk_f(input string name, input logic [FW-1:0] act, input logic [FW-1:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic cyc(input int unsigned n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Offer one word and return #1 after the edge that accepted it.
    task automatic send(input int unsigned w);
        logic ok;
        int   t;
        bus.s_in_v = 1'b1;
        bus.s_in   = DW'(w);
        ok = 1'b0;
        t  = 0;
        while (!ok && t < 50) begin
            @(negedge clk);
            ok = bus.s_in_rdy;
            @(posedge clk);
            #1;
            t++;
        end
        if (!ok) begin
            n_vec++;
            n_err++;
            $display("FAIL send_timeout: word %0d not accepted, expected acceptance", w);
        end
        bus.s_in_v = 1'b0;
    endtask

`ifdef SIPO_FLUSH_EN
    task automatic send_last(input int unsigned w);
        bus.s_in_last = 1'b1;
        send(w);
        bus.s_in_last = 1'b0;
    endtask
`endif

    // Monitor: every output handshake must match the head of the expected queue.
    always @(negedge clk) begin : monitor
        exp_t e;
        if (!rst && bus.p_out_v && bus.p_out_rdy) begin
            if (exp_q.size() == 0) begin
                n_vec++;
                n_err++;
                $display("FAIL unexpected_frame: got %h expected none", bus.p_out);
            end else begin
                e = exp_q.pop_front();
                chk_f("frame", bus.p_out, e.frame);
`ifdef SIPO_FLUSH_EN
                chk_f("frame_cnt", FW'(bus.p_out_cnt), FW'(e.cnt));
`endif
            end
        end
    end

    initial begin
        rst           = 1'b1;
        bus.s_in_v    = 1'b0;
        bus.s_in      = '0;
        bus.p_out_rdy = 1'b0;
`ifdef SIPO_FLUSH_EN
        bus.s_in_last = 1'b0;
`endif
        cyc(2);
        chk_b("rst_v", bus.p_out_v, 1'b0);
        chk_f("rst_p_out", bus.p_out, '0);
        chk_b("rst_rdy", bus.s_in_rdy, 1'b1);
        rst = 1'b0;

        // T1: back-to-back stream, sink always ready
        bus.p_out_rdy = 1'b1;
        push(seq(1, 8), 8);
        push(seq(9, 8), 8);
        for (int unsigned i = 1; i <= 16; i++) begin
            send(i);
            chk_b("t1_rdy", bus.s_in_rdy, 1'b1);
            chk_b("t1_v", bus.p_out_v, (i % 8) == 0);
        end
        cyc(1);

        // T2: sink stalled, skid fills, then drains
        bus.p_out_rdy = 1'b0;
        push(seq(1, 8), 8);
        push(seq(9, 8), 8);
        push(seq(17, 8), 8);
        for (int unsigned i = 1; i <= 16; i++) send(i);
        chk_b("t2_rdy_low", bus.s_in_rdy, 1'b0);
        bus.s_in_v = 1'b1;
        bus.s_in   = DW'(17);
        cyc(3);
        chk_b("t2_rdy_stall", bus.s_in_rdy, 1'b0);
        chk_b("t2_v_hold", bus.p_out_v, 1'b1);
        chk_f("t2_p_out_hold", bus.p_out, seq(1, 8));
        bus.p_out_rdy = 1'b1;
        cyc(1);
        bus.p_out_rdy = 1'b0;
        chk_b("t2_v_swap", bus.p_out_v, 1'b1);
        chk_f("t2_p_out_swap", bus.p_out, seq(9, 8));
        chk_b("t2_rdy_back", bus.s_in_rdy, 1'b1);
        for (int unsigned i = 17; i <= 24; i++) send(i);
        chk_b("t2_rdy_pend2", bus.s_in_rdy, 1'b0);
        bus.p_out_rdy = 1'b1;
        cyc(3);
        chk_b("t2_v_drained", bus.p_out_v, 1'b0);
        chk_b("t2_rdy_drained", bus.s_in_rdy, 1'b1);

        // T3: bubbles between words
        push(seq(1, 8), 8);
        for (int unsigned i = 1; i <= 8; i++) begin
            send(i);
            chk_b("t3_v", bus.p_out_v, i == 8);
            cyc(1);
            chk_b("t3_v_bubble", bus.p_out_v, 1'b0);
        end

        // T4: reset mid-frame discards the partial frame
        for (int unsigned i = 1; i <= 5; i++) send(i);
        rst = 1'b1;
        cyc(1);
        chk_b("t4_rst_v", bus.p_out_v, 1'b0);
        chk_f("t4_rst_p_out", bus.p_out, '0);
        chk_b("t4_rst_rdy", bus.s_in_rdy, 1'b1);
`ifdef SIPO_FLUSH_EN
        chk_f("t4_rst_cnt", FW'(bus.p_out_cnt), '0);
`endif
        rst = 1'b0;
        push(seq(11, 8), 8);
        for (int unsigned i = 11; i <= 18; i++) send(i);
        chk_b("t4_v", bus.p_out_v, 1'b1);
        cyc(1);

        // T5: frame 2 completes on the edge where frame 1 handshakes
        bus.p_out_rdy = 1'b0;
        push(seq(1, 8), 8);
        push(seq(9, 8), 8);
        for (int unsigned i = 1; i <= 15; i++) send(i);
        chk_b("t5_v_held", bus.p_out_v, 1'b1);
        chk_b("t5_rdy", bus.s_in_rdy, 1'b1);
        bus.p_out_rdy = 1'b1;
        send(16);
        chk_b("t5_v_back2back", bus.p_out_v, 1'b1);
        chk_f("t5_p_out", bus.p_out, seq(9, 8));
        chk_b("t5_rdy_nopend", bus.s_in_rdy, 1'b1);
        cyc(1);
        chk_b("t5_v_end", bus.p_out_v, 1'b0);

`ifdef SIPO_FLUSH_EN
        // T6: early close on word 3, next frame restarts at lane 0
        push(seq(1, 3), 3);
        send(1);
        send(2);
        send_last(3);
        chk_b("t6_v", bus.p_out_v, 1'b1);
        chk_f("t6_cnt", FW'(bus.p_out_cnt), FW'(3));
        chk_f("t6_p_out", bus.p_out, seq(1, 3));
        push(seq(4, 8), 8);
        for (int unsigned i = 4; i <= 11; i++) send(i);
        chk_f("t6_cnt_full", FW'(bus.p_out_cnt), FW'(8));
        cyc(1);
`endif

        for (int t = 0; t < 20 && exp_q.size() != 0; t++) cyc(1);
        chk_f("drain", FW'(exp_q.size()), '0);
        cyc(2);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
